dec_expgob: RTL and testbench
=============================

DEC_EXPGOB -- requirements
Module: dec_expgob

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: clock port clk, reset port rst.
REQ-002 Parameter MAX_PFX, default 8, is the maximum legal prefix zero count and is sized for 8-bit data.
REQ-003 Port list (name, direction, width, meaning):
- clk, in, 1: rising-edge clock.
- rst, in, 1: synchronous active-high reset.
- bit_i, in, 1: serial exp-Golomb code bit, MSB of the codeword first.
- bit_vld_i, in, 1: bit_i is valid this cycle; gaps are allowed.
- dt_o, out, 8: decoded value.
- dt_vld_o, out, 1: one-cycle pulse; dt_o is valid.
- err_o, out, 1: one-cycle pulse; a malformed codeword was discarded.
- busy_o, out, 1: a codeword is partially received.

Function
REQ-004 The block SHALL decode order-0 exp-Golomb codes: N zeros, then a 1, then N suffix bits form code value c = {1, suffix}; decoded value = c - 1.
REQ-005 The FSM SHALL have three states: PFX (counting zeros), SFX (shifting suffix), ERR (discard).
REQ-006 The FSM SHALL consume a bit only in cycles where bit_vld_i = 1; with bit_vld_i = 0 all state SHALL hold.
REQ-007 In PFX:
- A valid 0 SHALL increment the 4-bit zero counter zc.
- A valid 1 with zc = 0 SHALL emit value 0 and stay in PFX.
- A valid 1 with zc > 0 SHALL load accumulator acc = 1, load remaining count rc = zc, and go to SFX.
REQ-008 In SFX, each valid bit SHALL do acc <= {acc, bit_i} and rc <= rc - 1; when rc reaches 0 on that bit, the FSM SHALL complete the codeword and return to PFX with zc = 0.
REQ-009 acc SHALL be 9 bits wide. On completion:
- If acc <= 256, the block SHALL emit dt_o = acc - 1 (truncated to 8 bits).
- If acc > 256 (value > 255), the block SHALL pulse err_o instead.
REQ-010 A valid 0 arriving in PFX when zc = MAX_PFX (the 9th zero) SHALL pulse err_o and move to ERR.
REQ-011 In ERR, the block SHALL discard valid 0 bits; the first valid 1 SHALL return the FSM to PFX with zc = 0 and SHALL NOT emit a value (resync on the next codeword start).
REQ-012 dt_o and dt_vld_o SHALL be registered: dt_vld_o rises exactly one cycle after the clock edge that samples the final bit of a codeword.
REQ-013 dt_o SHALL hold its last decoded value between pulses.
REQ-014 dt_vld_o and err_o SHALL never be asserted in the same cycle.
REQ-015 Back-to-back codewords with no idle bits between them SHALL decode correctly, including consecutive value-0 codewords ("1","1") producing pulses on consecutive cycles.
REQ-016 busy_o SHALL be 1 when in SFX, or in PFX with zc > 0; it SHALL be 0 otherwise.

Reset
REQ-017 On rst = 1 at a clock edge:
- state = PFX, zc = 0, rc = 0, acc = 0.
- dt_o = 8'h00, dt_vld_o = 0, err_o = 0, busy_o = 0.
REQ-018 Reset SHALL take priority over bit_vld_i; a partial codeword in progress SHALL be dropped with no output pulse.

Structure
REQ-019 The shared package expgob_pkg SHALL hold:
- the state enum type (PFX, SFX, ERR);
- MAX_PFX = 8;
- the data-width constant DT_W = 8, also used by the encoder.
REQ-020 The block SHALL be a single module with no sub-modules; all counters and the accumulator SHALL be in one sequential process plus a next-state combinational process.

Verification
REQ-021 Value 0: a single valid bit "1" -> dt_vld_o pulse one cycle later, dt_o = 0.
REQ-022 Value 4: bits "00101" with bit_vld_i toggling 1,0,1,0,... -> a single dt_vld_o pulse, dt_o = 4, busy_o = 1 during the gaps.
REQ-023 Value 255: 8 zeros, 1, then "00000000" -> dt_o = 255; then 8 zeros, 1, "00000001" -> err_o pulse and no dt_vld_o.
REQ-024 Nine consecutive zeros -> err_o pulse on the cycle after the 9th zero; then "1" (dropped, resync); then "011" -> dt_o = 2.
REQ-025 Stream "1","010","011","1" back to back -> dt_o sequence 0, 1, 2, 0 with no missed pulses.
REQ-026 rst asserted for one cycle after "0010" -> no pulse, busy_o = 0; then "1" -> dt_o = 0.

Source files
------------

// File: rtl/expgob_pkg.sv
// -----------------------------------------------------------------------------
// expgob_pkg
//   Shared definitions for the order-0 exp-Golomb codec blocks.
//   - state_t : decoder FSM states (PFX = counting leading zeros,
//               SFX = shifting suffix bits, ERR = discarding until resync)
//   - MAX_PFX : largest legal prefix zero count for 8-bit values
//   - DT_W    : decoded / encoded data width
//   - expgob_len : codeword length in bits for a value (used by the encoder)
// -----------------------------------------------------------------------------
package expgob_pkg;

  localparam int DT_W    = 8;
  localparam int MAX_PFX = 8;

  typedef enum logic [1:0] {
    PFX = 2'd0,
    SFX = 2'd1,
    ERR = 2'd2
  } state_t;

  // Length of the order-0 exp-Golomb codeword carrying value v:
  // 2*floor(log2(v+1)) + 1 bits.
  function automatic int unsigned expgob_len(input logic [DT_W-1:0] v);
    logic [DT_W:0] c;
    int unsigned   n;
    c = {1'b0, v} + 1'b1;
    n = 0;
    for (int i = 0; i <= DT_W; i++) begin
      if (c[i]) n = i;
    end
    return 2 * n + 1;
  endfunction

endpackage

// File: rtl/dec_expgob.sv
// -----------------------------------------------------------------------------
// dec_expgob
//   Serial order-0 exp-Golomb decoder. A codeword is N zeros, a one, then N
//   suffix bits; the code value c = {1, suffix} and the decoded value is c-1.
//   Codewords whose value exceeds 255, or whose prefix runs past MAX_PFX
//   zeros, are reported on err_o and dropped.
//
// Ports
//   clk       : rising-edge clock
//   rst       : synchronous active-high reset
//   bit_i     : serial code bit, codeword MSB first
//   bit_vld_i : bit_i is valid this cycle (gaps allowed)
//   dt_o      : decoded value, held between pulses
//   dt_vld_o  : one-cycle pulse, dt_o carries a new value
//   err_o     : one-cycle pulse, a malformed codeword was discarded
//   busy_o    : a codeword is partially received
// -----------------------------------------------------------------------------
module dec_expgob
  import expgob_pkg::*;
#(
  parameter int MAX_PFX = expgob_pkg::MAX_PFX
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            bit_i,
  input  logic            bit_vld_i,
  output logic [DT_W-1:0] dt_o,
  output logic            dt_vld_o,
  output logic            err_o,
  output logic            busy_o
);

  localparam logic [3:0] ZC_MAX = 4'(MAX_PFX);

  state_t          state, state_nx;
  logic [3:0]      zc, zc_nx;
  logic [3:0]      rc, rc_nx;
  logic [DT_W:0]   acc, acc_nx;
  logic [DT_W:0]   acc_shift;
  logic [DT_W-1:0] dt_nx;
  logic            emit_nx;
  logic            err_nx;

  // Code value c maps to c-1; anything above 2^DT_W does not fit DT_W bits.
  function automatic logic code_fits(input logic [DT_W:0] c);
    return c <= (DT_W+1)'(1 << DT_W);
  endfunction

  function automatic logic [DT_W-1:0] code_to_value(input logic [DT_W:0] c);
    logic [DT_W:0] d;
    d = c - 1'b1;
    return d[DT_W-1:0];
  endfunction

  assign acc_shift = {acc[DT_W-1:0], bit_i};

  // Next-state and output decode; everything holds when no valid bit arrives.
  always_comb begin
    state_nx = state;
    zc_nx    = zc;
    rc_nx    = rc;
    acc_nx   = acc;
    dt_nx    = dt_o;
    emit_nx  = 1'b0;
    err_nx   = 1'b0;
    if (bit_vld_i) begin
      unique case (state)
        PFX: begin
          if (!bit_i) begin
            if (zc == ZC_MAX) begin
              // Prefix longer than any legal codeword: flag and resync.
              err_nx   = 1'b1;
              zc_nx    = '0;
              state_nx = ERR;
            end else begin
              zc_nx = zc + 4'd1;
            end
          end else if (zc == '0) begin
            // Codeword "1" has no suffix and decodes to zero immediately.
            emit_nx = 1'b1;
            dt_nx   = '0;
          end else begin
            acc_nx   = (DT_W+1)'(1);
            rc_nx    = zc;
            state_nx = SFX;
          end
        end
        SFX: begin
          acc_nx = acc_shift;
          rc_nx  = rc - 4'd1;
          if (rc == 4'd1) begin
            zc_nx    = '0;
            state_nx = PFX;
            if (code_fits(acc_shift)) begin
              emit_nx = 1'b1;
              dt_nx   = code_to_value(acc_shift);
            end else begin
              err_nx = 1'b1;
            end
          end
        end
        ERR: begin
          // A one marks the start of the next codeword's boundary; it is
          // consumed here without producing a value.
          if (bit_i) begin
            zc_nx    = '0;
            state_nx = PFX;
          end
        end
        default: begin
          zc_nx    = '0;
          state_nx = PFX;
        end
      endcase
    end
  end

  // Registered state, counters, accumulator and outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= PFX;
      zc       <= '0;
      rc       <= '0;
      acc      <= '0;
      dt_o     <= '0;
      dt_vld_o <= 1'b0;
      err_o    <= 1'b0;
    end else begin
      state    <= state_nx;
      zc       <= zc_nx;
      rc       <= rc_nx;
      acc      <= acc_nx;
      dt_o     <= dt_nx;
      dt_vld_o <= emit_nx;
      err_o    <= err_nx;
    end
  end

  assign busy_o = (state == SFX) || ((state == PFX) && (zc != '0));

endmodule

// File: tb/tb_dec_expgob.sv
module tb_dec_expgob;

  logic       clk = 1'b0;
  logic       rst;
  logic       bit_i;
  logic       bit_vld_i;
  logic [7:0] dt_o;
  logic       dt_vld_o;
  logic       err_o;
  logic       busy_o;

  dec_expgob #(.MAX_PFX(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .bit_i    (bit_i),
    .bit_vld_i(bit_vld_i),
    .dt_o     (dt_o),
    .dt_vld_o (dt_vld_o),
    .err_o    (err_o),
    .busy_o   (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_err;
    logic [7:0] val;
    int         stamp;
  } exp_t;

  exp_t q[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  logic rst_q    = 1'b1;
  logic [7:0] last_val = 8'h00;

  always @(posedge clk) begin
    cyc   <= cyc + 1;
    rst_q <= rst;
  end

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Monitor: compares every output pulse with the scoreboard head.
  always @(negedge clk) begin
    if (rst_q) begin
      chk("rst_dt_vld", int'(dt_vld_o), 0);
      chk("rst_err", int'(err_o), 0);
      chk("rst_dt", int'(dt_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      last_val = 8'h00;
    end else begin
      if (dt_vld_o === 1'b1 && err_o === 1'b1) chk("vld_err_overlap", 1, 0);
      if (dt_vld_o === 1'b1 || err_o === 1'b1) begin
        if (q.size() == 0) begin
          chk("unexpected_pulse", int'({dt_vld_o, err_o}), 0);
        end else begin
          exp_t e;
          e = q.pop_front();
          chk("pulse_kind_err", int'(err_o), int'(e.is_err));
          chk("pulse_latency", cyc, e.stamp);
          if (!e.is_err) begin
            chk("dt_value", int'(dt_o), int'(e.val));
            last_val = e.val;
          end else begin
            chk("dt_hold_on_err", int'(dt_o), int'(last_val));
          end
        end
      end else begin
        chk("dt_hold", int'(dt_o), int'(last_val));
      end
    end
  end

  task automatic send_bit(input logic b, input logic exp_busy, input int gap,
                          input bit push, input bit push_err, input logic [7:0] pv);
    exp_t e;
    @(negedge clk);
    bit_i     = b;
    bit_vld_i = 1'b1;
    if (push) begin
      e.is_err = push_err;
      e.val    = pv;
      e.stamp  = cyc + 1;
      q.push_back(e);
    end
    for (int i = 0; i < gap; i++) begin
      @(negedge clk);
      bit_vld_i = 1'b0;
      bit_i     = $urandom_range(1, 0);
      chk("busy", int'(busy_o), int'(exp_busy));
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      bit_vld_i = 1'b0;
    end
  endtask

  // Emit the codeword for code value c (= value + 1); values above 255
  // are expected to be rejected.
  task automatic send_code(input int c, input int gmin, input int gmax);
    int  n;
    bit  last;
    n = 0;
    while ((c >> (n + 1)) != 0) n++;
    for (int i = 0; i < n; i++)
      send_bit(1'b0, 1'b1, $urandom_range(gmax, gmin), 0, 0, 8'h00);
    for (int i = n; i >= 0; i--) begin
      last = (i == 0);
      send_bit(logic'((c >> i) & 1), !last, $urandom_range(gmax, gmin),
               last, (c - 1) > 255, 8'((c - 1) & 255));
    end
  endtask

  // Nine zeros (error on the ninth), extra discarded zeros, then the resync one.
  task automatic send_pfx_err(input int junk, input int gmax);
    for (int i = 0; i < 8; i++) send_bit(1'b0, 1'b1, $urandom_range(gmax, 0), 0, 0, 8'h00);
    send_bit(1'b0, 1'b0, $urandom_range(gmax, 0), 1, 1, 8'h00);
    for (int i = 0; i < junk; i++) send_bit(1'b0, 1'b0, $urandom_range(gmax, 0), 0, 0, 8'h00);
    send_bit(1'b1, 1'b0, $urandom_range(gmax, 0), 0, 0, 8'h00);
  endtask

  task automatic do_reset();
    @(negedge clk);
    bit_vld_i = 1'b0;
    rst       = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("busy_after_rst", int'(busy_o), 0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int r, n, c, hi;
    rst       = 1'b1;
    bit_i     = 1'b0;
    bit_vld_i = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("busy_idle", int'(busy_o), 0);

    // Value 0
    send_code(1, 0, 0);
    idle(2);
    // Value 4 with a gap after every bit
    send_code(5, 1, 1);
    idle(1);
    // Largest legal value, then the smallest overflowing code
    send_code(256, 0, 0);
    send_code(257, 0, 0);
    idle(2);
    // Over-long prefix, resync, then value 2
    send_pfx_err(0, 0);
    send_code(3, 0, 0);
    idle(2);
    // Back-to-back 0,1,2,0
    send_code(1, 0, 0);
    send_code(2, 0, 0);
    send_code(3, 0, 0);
    send_code(1, 0, 0);
    idle(2);
    // Reset drops a partial codeword
    send_bit(1'b0, 1'b1, 1, 0, 0, 8'h00);
    send_bit(1'b0, 1'b1, 1, 0, 0, 8'h00);
    send_bit(1'b1, 1'b1, 1, 0, 0, 8'h00);
    send_bit(1'b0, 1'b1, 1, 0, 0, 8'h00);
    do_reset();
    send_code(1, 0, 0);
    idle(2);

    // Randomized mix
    for (int k = 0; k < 120; k++) begin
      r = $urandom_range(11, 0);
      if (r == 0) begin
        send_code($urandom_range(511, 257), 0, $urandom_range(2, 0));
      end else if (r == 1) begin
        send_pfx_err($urandom_range(3, 0), $urandom_range(2, 0));
      end else if (r == 2) begin
        n = $urandom_range(8, 1);
        for (int i = 0; i < n; i++) send_bit(1'b0, 1'b1, 1, 0, 0, 8'h00);
        do_reset();
      end else begin
        n  = $urandom_range(8, 0);
        hi = (2 << n) - 1;
        if (hi > 256) hi = 256;
        c  = $urandom_range(hi, 1 << n);
        send_code(c, 0, $urandom_range(2, 0));
      end
    end
    idle(4);
    chk("scoreboard_empty", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
